// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: {remainder, quotient} after 33 edges (1 edge for /0).
// Operands are latched at accept; result and ready are held while start_i stays high.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t      state, state_nxt;
    logic [64:0] work;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic        sgn1, sgn2, sgn_mode;

    logic        accept;
    logic [31:0] abs1, abs2;
    logic [32:0] trial;
    logic [31:0] quot_fix, rem_fix;

    always_comb begin
        accept   = start_i && !annul_i;
        abs1     = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        abs2     = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
        trial    = {1'b0, work[63:32]} - {1'b0, dvs};
        // Quotient is negative when operand signs differ; remainder follows the dividend.
        quot_fix = (sgn_mode && (sgn1 ^ sgn2)) ? (~work[31:0] + 32'd1) : work[31:0];
        rem_fix  = (sgn_mode && sgn1) ? (~work[64:33] + 32'd1) : work[64:33];

        state_nxt = state;
        case (state)
            S_FREE: begin
                if (accept)
                    state_nxt = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
            end
            S_BYZERO: state_nxt = S_END;
            S_ON: begin
                if (annul_i)
                    state_nxt = S_FREE;
                else if (cnt == 6'd32)
                    state_nxt = S_END;
            end
            S_END: begin
                if (!start_i)
                    state_nxt = S_FREE;
            end
            default: state_nxt = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FREE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            dvs      <= '0;
            cnt      <= '0;
            sgn1     <= 1'b0;
            sgn2     <= 1'b0;
            sgn_mode <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept && (opdata2_i != 32'd0)) begin
                        // Dividend sits at [32:1] so the first shift brings its MSB into the remainder.
                        work     <= {32'd0, abs1, 1'b0};
                        dvs      <= abs2;
                        cnt      <= '0;
                        sgn1     <= opdata1_i[31];
                        sgn2     <= opdata2_i[31];
                        sgn_mode <= signed_div_i;
                    end
                end
                S_BYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                S_ON: begin
                    if (annul_i) begin
                        cnt     <= '0;
                        ready_o <= 1'b0;
                    end else if (cnt != 6'd32) begin
                        if (trial[32])
                            work <= {work[63:0], 1'b0};
                        else
                            work <= {trial[31:0], work[31:0], 1'b1};
                        cnt <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem_fix, quot_fix};
                        ready_o  <= 1'b1;
                        cnt      <= '0;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed corner cases plus randomized DIV/DIVU against an arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, q, r;
        if (b == 32'd0) return 64'd0;
        ma = (sd && a[31]) ? -longint'($signed(a)) : longint'(a);
        mb = (sd && b[31]) ? -longint'($signed(b)) : longint'(b);
        q = ma / mb;
        r = ma % mb;
        if (sd && (a[31] ^ b[31])) q = -q;
        if (sd && a[31]) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit sd, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sd;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Counts edges until ready_o is seen; lat = -1 if the budget runs out.
    task automatic wait_ready(output int lat, output logic [63:0] res);
        lat = -1;
        res = 'x;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (ready_o) begin
                lat = i;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic run_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res);
        launch(sd, a, b);
        wait_ready(lat, res);
    endtask

    task automatic drop_start();
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        tick(); tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++;
        if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        bit          sd_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] a_t  [5] = '{32'd7, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] b_t  [5] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1};
        logic [63:0] e_t  [5] = '{64'h00000001_00000003, 64'hFFFFFFFF_FFFFFFFD,
                                  64'h00000001_FFFFFFFD, 64'h00000000_80000000,
                                  64'h00000000_FFFFFFFF};
        int lat;
        logic [63:0] res;
        for (int i = 0; i < 5; i++) begin
            run_div(sd_t[i], a_t[i], b_t[i], lat, res);
            checks++;
            if (lat !== 34) begin errors++; $display("FAIL directed%0d_latency: got %0d want 34", i, lat); end
            checks++;
            if (res !== e_t[i]) begin errors++; $display("FAIL directed%0d_result: got %h want %h", i, res, e_t[i]); end
            drop_start();
            checks++;
            if (ready_o !== 1'b0 || result_o !== 64'd0) begin
                errors++; $display("FAIL directed%0d_release: got ready=%b result=%h want 0/0", i, ready_o, result_o);
            end
        end
    endtask

    task automatic test_byzero();
        int lat;
        logic [63:0] res;
        run_div(1'b1, 32'd1234, 32'd0, lat, res);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL byzero_latency: got %0d want 2", lat); end
        checks++;
        if (res !== 64'd0) begin errors++; $display("FAIL byzero_result: got %h want 0", res); end
        // annul while holding the result must not disturb it
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL byzero_end_annul: got ready=%b want 1", ready_o); end
        drop_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL byzero_release: got ready=%b result=%h want 0/0", ready_o, result_o);
        end
    endtask

    task automatic test_annul();
        int lat;
        bit seen;
        logic [63:0] res;
        launch(1'b0, 32'd1000, 32'd3);
        for (int i = 0; i < 11; i++) tick();   // accept + 10 iterations
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ready_o) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL annul_on: got ready seen=%b want 0", seen); end
        run_div(1'b1, 32'hFFFFFC18, 32'd7, lat, res);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL annul_restart_latency: got %0d want 34", lat); end
        checks++;
        if (res !== ref_div(1'b1, 32'hFFFFFC18, 32'd7)) begin
            errors++; $display("FAIL annul_restart_result: got %h want %h", res, ref_div(1'b1, 32'hFFFFFC18, 32'd7));
        end
        drop_start();
        // annul held in FREE blocks acceptance; release counts as the start
        launch(1'b0, 32'd50, 32'd5);
        annul_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        annul_i = 1'b0;
        wait_ready(lat, res);
        checks++;
        if (lat !== 34) begin errors++; $display("FAIL annul_free_block: got latency %0d want 34", lat); end
        drop_start();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [63:0] res;
        launch(1'b0, 32'd999, 32'd4);
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1; start_i = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got ready=%b result=%h want 0/0", ready_o, result_o);
        end
        // operands change after accept; result must use the latched ones
        launch(1'b1, 32'hFFFF0001, 32'd13);
        tick();
        signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0;
        wait_ready(lat, res);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL latch_latency: got %0d want 33", lat); end
        checks++;
        if (res !== ref_div(1'b1, 32'hFFFF0001, 32'd13)) begin
            errors++; $display("FAIL latch_result: got %h want %h", res, ref_div(1'b1, 32'hFFFF0001, 32'd13));
        end
        drop_start();
    endtask

    task automatic test_start_drop();
        int lat;
        logic [63:0] res;
        launch(1'b1, 32'd12345, 32'hFFFFFFF6);
        for (int i = 0; i < 5; i++) tick();
        start_i = 1'b0;
        wait_ready(lat, res);
        checks++;
        if (lat !== 29) begin errors++; $display("FAIL drop_latency: got %0d want 29", lat); end
        checks++;
        if (res !== ref_div(1'b1, 32'd12345, 32'hFFFFFFF6)) begin
            errors++; $display("FAIL drop_result: got %h want %h", res, ref_div(1'b1, 32'd12345, 32'hFFFFFFF6));
        end
        tick();
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL drop_release: got ready=%b want 0", ready_o); end
    endtask

    task automatic test_random();
        int lat, exp_lat;
        bit sd;
        logic [31:0] a, b;
        logic [63:0] res, exp;
        for (int n = 0; n < 40; n++) begin
            sd = 1'($urandom_range(1, 0));
            a  = $urandom;
            case ($urandom_range(7, 0))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2, 3:    b = $urandom_range(20, 1);
                default: b = $urandom;
            endcase
            if ($urandom_range(3, 0) == 0) a = $urandom_range(100, 0);
            exp     = ref_div(sd, a, b);
            exp_lat = (b == 32'd0) ? 2 : 34;
            run_div(sd, a, b, lat, res);
            checks++;
            if (lat !== exp_lat) begin
                errors++; $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, exp_lat);
            end
            checks++;
            if (res !== exp) begin
                errors++; $display("FAIL rand%0d_result sd=%0d a=%h b=%h: got %h want %h", n, sd, a, b, res, exp);
            end
            drop_start();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_byzero();
        test_annul();
        test_reset_mid();
        test_start_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
